// File: rtl/tile_map_engine.sv
// rtl/tile_map_engine.sv - tile map store with ROM loader, pixel sprite lookup and tile query/write port
module tile_map_engine #(
  parameter int GRID_W    = 41,
  parameter int GRID_H    = 41,
  parameter int CELL      = 5,
  parameter int ORG_X     = 60,
  parameter int ORG_Y     = 30,
  parameter int TILE_BITS = 2,
  parameter int NUM_MAPS  = 4,
  parameter int ROW_WALL  = 120,
  parameter int ROW_ITEM  = 125,
  parameter int ROW_EXIT  = 130
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_req,
  input  logic [1:0]           load_sel,
  output logic [12:0]          rom_addr,
  input  logic [TILE_BITS-1:0] rom_data,
  output logic                 busy,
  input  logic [9:0]           h_cnt,
  input  logic [9:0]           v_cnt,
  output logic [16:0]          pixel_addr,
  output logic                 isObject,
  input  logic                 w_en,
  input  logic [5:0]           w_col,
  input  logic [5:0]           w_row,
  input  logic [TILE_BITS-1:0] w_data,
  input  logic                 q_valid,
  input  logic [5:0]           q_col,
  input  logic [5:0]           q_row,
  output logic                 q_ack,
  output logic [TILE_BITS-1:0] q_tile,
  output logic [10:0]          item_count,
  output logic                 items_zero
);

  localparam int NTILES = GRID_W * GRID_H;
  localparam int IDX_W  = 11;
  localparam int MAP_W  = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
  localparam int OFF_W  = $clog2(CELL);

  localparam logic [TILE_BITS-1:0] T_EMPTY = TILE_BITS'(0);
  localparam logic [TILE_BITS-1:0] T_WALL  = TILE_BITS'(1);
  localparam logic [TILE_BITS-1:0] T_ITEM  = TILE_BITS'(2);
  localparam logic [TILE_BITS-1:0] T_EXIT  = TILE_BITS'(3);
  localparam logic [10:0]          CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

  // Tile storage deliberately has no reset: an aborted load leaves a partial map behind.
  logic [TILE_BITS-1:0] tiles [0:NTILES-1];

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [MAP_W-1:0] sel_q;
  logic             wr_pend;
  logic [IDX_W-1:0] wr_idx;

  function automatic logic [IDX_W-1:0] tile_index(input logic [5:0] col, input logic [5:0] row);
    return IDX_W'(row) * IDX_W'(GRID_W) + IDX_W'(col);
  endfunction

  assign rom_addr   = {2'(sel_q), idx};
  assign items_zero = (item_count == '0) && !busy;

  // User write / query decode; coordinates outside the grid never touch storage.
  logic                 w_in, q_in, user_wr;
  logic [IDX_W-1:0]     w_idx, q_idx;
  logic [TILE_BITS-1:0] w_old;

  assign w_in    = (w_col < 6'(GRID_W)) && (w_row < 6'(GRID_H));
  assign q_in    = (q_col < 6'(GRID_W)) && (q_row < 6'(GRID_H));
  assign w_idx   = w_in ? tile_index(w_col, w_row) : '0;
  assign q_idx   = q_in ? tile_index(q_col, q_row) : '0;
  assign user_wr = w_en && w_in && !busy;
  assign w_old   = tiles[w_idx];

  // Loader FSM: issue one ROM address per cycle, write each datum one cycle later, track ITEM count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      idx        <= '0;
      sel_q      <= '0;
      wr_pend    <= 1'b0;
      wr_idx     <= '0;
      item_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_req) begin
            state      <= S_LOAD;
            busy       <= 1'b1;
            idx        <= '0;
            sel_q      <= load_sel[MAP_W-1:0];
            wr_pend    <= 1'b0;
            item_count <= '0;
          end else if (user_wr) begin
            if (w_old == T_ITEM && w_data != T_ITEM) begin
              if (item_count != '0) item_count <= item_count - 11'd1;
            end else if (w_old != T_ITEM && w_data == T_ITEM) begin
              if (item_count != CNT_MAX) item_count <= item_count + 11'd1;
            end
          end
        end
        S_LOAD: begin
          if (wr_pend && rom_data == T_ITEM && item_count != CNT_MAX)
            item_count <= item_count + 11'd1;
          wr_pend <= 1'b1;
          wr_idx  <= idx;
          if (idx == IDX_W'(NTILES - 1)) state <= S_FLUSH;
          else                           idx   <= idx + 1'b1;
        end
        S_FLUSH: begin
          if (wr_pend && rom_data == T_ITEM && item_count != CNT_MAX)
            item_count <= item_count + 11'd1;
          wr_pend <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tile store writes: loader data lands behind its address; user writes only happen while idle.
  always_ff @(posedge clk) begin
    if (wr_pend)      tiles[wr_idx] <= rom_data;
    else if (user_wr) tiles[w_idx]  <= w_data;
  end

  // Query port: answer on the next cycle with the pre-write tile, WALL when busy or off-grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ack  <= 1'b0;
      q_tile <= '0;
    end else begin
      q_ack <= q_valid;
      if (q_valid) q_tile <= (busy || !q_in) ? T_WALL : tiles[q_idx];
    end
  end

  // Pixel stage-1 decode: half-res position, map bounds and tile index.
  logic [9:0]       px, py, px_off, py_off;
  logic             p_inside;
  logic [IDX_W-1:0] p_idx;

  assign px       = h_cnt >> 1;
  assign py       = v_cnt >> 1;
  assign px_off   = px - 10'(ORG_X);
  assign py_off   = py - 10'(ORG_Y);
  assign p_inside = (px >= 10'(ORG_X)) && (px < 10'(ORG_X + GRID_W * CELL)) &&
                    (py >= 10'(ORG_Y)) && (py < 10'(ORG_Y + GRID_H * CELL));
  assign p_idx    = p_inside ? (IDX_W'(py_off / 10'(CELL)) * IDX_W'(GRID_W) + IDX_W'(px_off / 10'(CELL)))
                             : '0;

  logic                 s1_valid;
  logic [TILE_BITS-1:0] s1_tile;
  logic [OFF_W-1:0]     s1_xo, s1_yo;

  // Pixel stage 1: fetch the tile under the pixel (same-cycle writes are not yet visible).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_tile  <= '0;
      s1_xo    <= '0;
      s1_yo    <= '0;
    end else begin
      s1_valid <= p_inside && !busy;
      s1_tile  <= tiles[p_idx];
      s1_xo    <= OFF_W'(px_off % 10'(CELL));
      s1_yo    <= OFF_W'(py_off % 10'(CELL));
    end
  end

  logic [16:0] row_t;

  // Sprite-sheet row for the fetched tile code.
  always_comb begin
    row_t = '0;
    case (s1_tile)
      T_WALL:  row_t = 17'(ROW_WALL);
      T_ITEM:  row_t = 17'(ROW_ITEM);
      T_EXIT:  row_t = 17'(ROW_EXIT);
      default: row_t = '0;
    endcase
  end

  // Pixel stage 2: registered sprite address, zero for empty or invalid pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isObject   <= 1'b0;
      pixel_addr <= '0;
    end else begin
      isObject   <= s1_valid && (s1_tile != T_EMPTY);
      pixel_addr <= (s1_valid && s1_tile != T_EMPTY)
                    ? 17'(s1_xo) + (17'(s1_yo) + row_t) * 17'd320
                    : '0;
    end
  end

endmodule

// File: doc/tile_map_engine.md
TILE_MAP_ENGINE -- requirements
Module: tile_map_engine

Interface
REQ-001 SHALL have parameters: GRID_W 41 (tile columns); GRID_H 41 (tile rows); CELL 5 (tile edge in half-res pixels); ORG_X 60 and ORG_Y 30 (half-res origin of the map); TILE_BITS 2; NUM_MAPS 4; ROW_WALL 120, ROW_ITEM 125, ROW_EXIT 130 (sprite-sheet rows).
REQ-002 SHALL have ports, one clock, reset asynchronous and active-low:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- load_req  in  1  one-cycle pulse that starts a map load
- load_sel  in  2  map index, sampled with load_req
- rom_addr  out  13  {load_sel, tile index}, tile index = row*GRID_W+col
- rom_data  in  TILE_BITS  tile code, valid 1 cycle after rom_addr
- busy  out  1  load in progress
- h_cnt, v_cnt  in  10 each  VGA counters
- pixel_addr  out  17  sprite-sheet address
- isObject  out  1  pixel belongs to a non-empty tile
- w_en  in  1  tile write strobe
- w_col, w_row  in  6 each  tile coordinates
- w_data  in  TILE_BITS  new code
- q_valid  in  1  query strobe
- q_col, q_row  in  6 each  query coordinates
- q_ack  out  1  query answer valid
- q_tile  out  TILE_BITS  queried code
- item_count  out  11  ITEM tiles remaining
- items_zero  out  1  item_count==0 and not busy

Function
REQ-003 Tile codes SHALL be 0 EMPTY, 1 WALL, 2 ITEM, 3 EXIT; storage SHALL be GRID_W*GRID_H internal tiles.
REQ-004 FSM SHALL have states IDLE, LOAD, FLUSH; load_req in IDLE -> LOAD with tile index 0, item counter cleared, busy=1.
REQ-005 In LOAD, rom_addr SHALL step one tile per cycle; each rom_data SHALL be written to the tile addressed one cycle earlier.
REQ-006 After the last address is issued -> FLUSH for one cycle to capture the final datum, then IDLE, busy=0.
REQ-007 During load, item_count SHALL increment for each ITEM datum written.
REQ-008 load_req while busy SHALL be ignored; load_sel SHALL be latched only on an accepted load_req.
REQ-009 Half-res coordinates: x=h_cnt>>1, y=v_cnt>>1; inside iff ORG_X<=x<ORG_X+GRID_W*CELL and ORG_Y<=y<ORG_Y+GRID_H*CELL.
REQ-010 Pixel path SHALL be a 2-stage pipeline: pixel_addr and isObject SHALL reflect h_cnt/v_cnt from 2 cycles earlier.
REQ-011 For inside tile T at col=(x-ORG_X)/CELL, row=(y-ORG_Y)/CELL with T!=EMPTY: isObject=1; pixel_addr=(x-ORG_X)%CELL + ((y-ORG_Y)%CELL + ROW_T)*320, where ROW_T is ROW_WALL, ROW_ITEM or ROW_EXIT.
REQ-012 Outside the map, on EMPTY tiles, or while busy: isObject=0 and pixel_addr=0.
REQ-013 A query SHALL give q_ack=1 for exactly the next cycle, with q_tile = stored code at query time.
REQ-014 A query with out-of-range coordinates, or made while busy, SHALL return q_tile=WALL.
REQ-015 A write SHALL update the tile at the clock edge; out-of-range writes and writes while busy SHALL be dropped.
REQ-016 Same-cycle write and query to the same tile SHALL return the pre-write value (read-before-write).
REQ-017 item_count SHALL decrement when a write replaces ITEM with a non-ITEM code and increment on the reverse; writing ITEM over ITEM SHALL leave it unchanged.
REQ-018 item_count SHALL saturate at 0 and at 2047.
REQ-019 A pixel read and a write to the same tile in one cycle SHALL let the pixel path see the old value.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, busy=0, rom_addr=0, pixel_addr=0, isObject=0, q_ack=0, q_tile=0, item_count=0, items_zero=1, and clear the pipeline valid flags.
REQ-021 Tile storage SHALL NOT be cleared by reset; a reset during LOAD SHALL abort it, leaving a partially updated map.

Verification
REQ-022 Load map 1 with ROM tile 0=WALL, 42=ITEM, rest EMPTY -> busy high for 1681+1 cycles after the pulse, then item_count=1 and items_zero=0.
REQ-023 h_cnt=120, v_cnt=60 on tile(0,0)=WALL -> 2 cycles later isObject=1, pixel_addr=38400; h_cnt=0 -> isObject=0, pixel_addr=0.
REQ-024 Query (1,1) and write EMPTY to (1,1) in the same cycle -> next cycle q_ack=1, q_tile=ITEM, then item_count=0 and items_zero=1.
REQ-025 Query (41,0) -> q_tile=WALL; write to (0,41) -> no tile changes.
REQ-026 load_req every cycle during a load -> only the first is accepted, and rom_addr runs 0..1680 exactly once.
REQ-027 rst_n low mid-load -> busy=0 and item_count=0 immediately; a later query of a tile already loaded returns its loaded value.
